// File: rtl/fft_frame_checker_if.sv
// Stream bundle between an FFT under test and its frame checker.
// The master side drives the input strobe, the FFT output stream and the golden
// stream. The slave side (the checker) returns the per-frame verdict, latency,
// energies and statistics.
//   in_valid, out_valid      strobes
//   dout_r/dout_i            FFT output, signed OUT_WIDTH
//   gold_r/gold_i            golden reference, signed OUT_WIDTH+1
//   done/pass/timeout/proto_err, latency, signal_energy, noise_energy,
//   frames_passed, worst_latency   checker results
interface fft_frame_checker_if #(
    parameter int OUT_WIDTH = 16,
    parameter int FFT_SIZE  = 32,
    parameter int ACC_W     = 2*(OUT_WIDTH+2)+$clog2(2*FFT_SIZE)
);
    logic                        in_valid;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] dout_r;
    logic signed [OUT_WIDTH-1:0] dout_i;
    logic signed [OUT_WIDTH:0]   gold_r;
    logic signed [OUT_WIDTH:0]   gold_i;
    logic                        done;
    logic                        pass;
    logic                        timeout;
    logic                        proto_err;
    logic [7:0]                  latency;
    logic [ACC_W-1:0]            signal_energy;
    logic [ACC_W-1:0]            noise_energy;
    logic [15:0]                 frames_passed;
    logic [7:0]                  worst_latency;

    modport master (
        output in_valid, out_valid, dout_r, dout_i, gold_r, gold_i,
        input  done, pass, timeout, proto_err, latency, signal_energy,
               noise_energy, frames_passed, worst_latency
    );

    modport slave (
        input  in_valid, out_valid, dout_r, dout_i, gold_r, gold_i,
        output done, pass, timeout, proto_err, latency, signal_energy,
               noise_energy, frames_passed, worst_latency
    );
endinterface

// File: rtl/fft_frame_checker.sv
// Per-frame monitor for the streaming FFT. Tracks the input handshake, measures
// latency (idle cycles after the last input plus output stalls), accumulates
// golden signal energy and error energy exactly, and gives a pass/fail verdict
// against an SNR ratio without any division.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         fft_frame_checker_if.slave (streams in, verdict/stats out)
// Optional build macro FFT_CHK_STATS_EN adds the frames_passed / worst_latency
// counters; without it both outputs are tied to zero.
//
// state | meaning
// IDLE  | waiting for first input sample
// LOAD  | counting input samples
// WAIT  | inputs complete, waiting for first output
// CHECK | accumulating output samples
// DONE  | verdict valid for one cycle
module fft_frame_checker #(
    parameter int FFT_SIZE      = 32,
    parameter int OUT_WIDTH     = 16,
    parameter int LATENCY_LIMIT = 68,
    parameter int SNR_RATIO     = 10000,
    parameter int ACC_W         = 2*(OUT_WIDTH+2)+$clog2(2*FFT_SIZE)
) (
    input logic              clk,
    input logic              reset,
    fft_frame_checker_if.slave bus
);
    localparam int CNT_W  = $clog2(FFT_SIZE)+1;
    localparam int DIFF_W = OUT_WIDTH+2;
    localparam int SQ_W   = 2*DIFF_W;
    localparam int CMP_W  = ACC_W+$clog2(SNR_RATIO+1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lat_q, lat_d;
    logic             timeout_q, timeout_d;
    logic             proto_q, proto_d;
    logic             pass_q, pass_d;
    logic [ACC_W-1:0] sig_q, sig_d;
    logic [ACC_W-1:0] noise_q, noise_d;

    function automatic logic [SQ_W-1:0] square(input logic signed [DIFF_W-1:0] v);
        logic signed [SQ_W-1:0] w;
        w = SQ_W'(v);
        return SQ_W'(w * w);
    endfunction

    // Everything widened to DIFF_W so gold - dout can never wrap.
    logic signed [DIFF_W-1:0] gr_x, gi_x, dr_x, di_x, er, ei;
    logic [ACC_W-1:0]         sig_inc, noise_inc;
    logic [7:0]               lat_inc;
    logic                     lat_over;
    logic                     start;
    logic                     verdict;
    logic [CMP_W-1:0]         s_ext, n_scaled;

    assign gr_x = {{(DIFF_W-OUT_WIDTH-1){bus.gold_r[OUT_WIDTH]}}, bus.gold_r};
    assign gi_x = {{(DIFF_W-OUT_WIDTH-1){bus.gold_i[OUT_WIDTH]}}, bus.gold_i};
    assign dr_x = {{(DIFF_W-OUT_WIDTH){bus.dout_r[OUT_WIDTH-1]}}, bus.dout_r};
    assign di_x = {{(DIFF_W-OUT_WIDTH){bus.dout_i[OUT_WIDTH-1]}}, bus.dout_i};
    assign er   = gr_x - dr_x;
    assign ei   = gi_x - di_x;

    assign sig_inc   = ACC_W'(square(gr_x)) + ACC_W'(square(gi_x));
    assign noise_inc = ACC_W'(square(er)) + ACC_W'(square(ei));

    assign lat_inc  = (lat_q == 8'hFF) ? lat_q : lat_q + 8'd1;
    assign lat_over = int'(lat_inc) > LATENCY_LIMIT;

    // S >= R*N; a zero noise energy satisfies this trivially.
    assign s_ext    = CMP_W'(sig_q);
    assign n_scaled = CMP_W'(noise_q) * CMP_W'(SNR_RATIO);
    assign verdict  = !timeout_q && !proto_q && (s_ext >= n_scaled);

    assign start = bus.in_valid && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        timeout_d = timeout_q;
        proto_d   = proto_q;
        pass_d    = pass_q;
        sig_d     = sig_q;
        noise_d   = noise_q;
        unique case (state_q)
            IDLE: ;
            LOAD: begin
                if (bus.out_valid) begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end else if (bus.in_valid) begin
                    if (cnt_q == CNT_W'(FFT_SIZE)) begin
                        proto_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == CNT_W'(FFT_SIZE)) begin
                    // The cycle in which in_valid drops is the first latency cycle.
                    cnt_d   = '0;
                    lat_d   = lat_inc;
                    state_d = WAIT;
                end else begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (bus.out_valid) begin
                    sig_d   = sig_q + sig_inc;
                    noise_d = noise_q + noise_inc;
                    cnt_d   = CNT_W'(1);
                    state_d = CHECK;
                end else begin
                    lat_d = lat_inc;
                    if (lat_over) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            CHECK: begin
                if (bus.in_valid) begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end else if (bus.out_valid) begin
                    sig_d   = sig_q + sig_inc;
                    noise_d = noise_q + noise_inc;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CNT_W'(FFT_SIZE))
                        state_d = DONE;
                end else begin
                    lat_d = lat_inc;
                    if (lat_over) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                pass_d  = verdict;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d   = LOAD;
            cnt_d     = CNT_W'(1);
            lat_d     = '0;
            timeout_d = 1'b0;
            proto_d   = 1'b0;
            pass_d    = 1'b0;
            sig_d     = '0;
            noise_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
            pass_q    <= 1'b0;
            sig_q     <= '0;
            noise_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
            pass_q    <= pass_d;
            sig_q     <= sig_d;
            noise_q   <= noise_d;
        end
    end

    // During DONE the verdict is shown live so it is valid alongside done.
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = (state_q == DONE) ? verdict : pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.proto_err     = proto_q;
    assign bus.latency       = lat_q;
    assign bus.signal_energy = sig_q;
    assign bus.noise_energy  = noise_q;

`ifdef FFT_CHK_STATS_EN
    logic [15:0] fp_q;
    logic [7:0]  wl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fp_q <= '0;
            wl_q <= '0;
        end else if (state_q == DONE && verdict) begin
            if (fp_q != 16'hFFFF)
                fp_q <= fp_q + 16'd1;
            if (lat_q > wl_q)
                wl_q <= lat_q;
        end
    end

    assign bus.frames_passed = fp_q;
    assign bus.worst_latency = wl_q;
`else
    assign bus.frames_passed = '0;
    assign bus.worst_latency = '0;
`endif
endmodule

// File: tb/tb_fft_frame_checker.sv
module tb_fft_frame_checker;
    localparam int FFT_SIZE = 32;
    localparam int OUT_W    = 16;
    localparam int LIMIT    = 68;
    localparam int SNR      = 10000;

    typedef struct {
        bit     pass_b;
        bit     timeout_b;
        bit     proto_b;
        longint lat;
        longint s;
        longint n;
        longint fp;
        longint wl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fft_frame_checker_if #(.OUT_WIDTH(OUT_W), .FFT_SIZE(FFT_SIZE)) bus ();

    fft_frame_checker #(
        .FFT_SIZE(FFT_SIZE), .OUT_WIDTH(OUT_W),
        .LATENCY_LIMIT(LIMIT), .SNR_RATIO(SNR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Current frame description
    int n_in, g0, iv_inject, idle_after;
    int gap[FFT_SIZE];
    int gr[FFT_SIZE], gi[FFT_SIZE], dr[FFT_SIZE], di[FFT_SIZE];

    longint m_fp = 0, m_wl = 0;
    exp_t   exp_q[$];

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: walk the frame description and apply the frame rules directly.
    function automatic exp_t model_frame();
        exp_t   e;
        longint s = 0, n = 0;
        int     cum = 0;
        int     zeros;
        e = '{default: 0};
        if (n_in != FFT_SIZE) begin
            e.proto_b = 1;
            return e;
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            zeros = (k == 0) ? g0 : gap[k-1];
            if (cum + zeros > LIMIT) begin
                e.timeout_b = 1;
                cum = LIMIT + 1;
                break;
            end
            cum += zeros;
            s += longint'(gr[k])*gr[k] + longint'(gi[k])*gi[k];
            n += longint'(gr[k]-dr[k])*(gr[k]-dr[k]) + longint'(gi[k]-di[k])*(gi[k]-di[k]);
            if (k == iv_inject) begin
                e.proto_b = 1;
                break;
            end
        end
        e.lat = cum;
        e.s = s;
        e.n = n;
        e.pass_b = !e.timeout_b && !e.proto_b && (n == 0 || s >= longint'(SNR)*n);
        return e;
    endfunction

    task automatic cyc(input logic iv, input logic ov, input int a_dr, input int a_di,
                       input int a_gr, input int a_gi);
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.out_valid = ov;
        bus.dout_r    = 16'(a_dr);
        bus.dout_i    = 16'(a_di);
        bus.gold_r    = 17'(a_gr);
        bus.gold_i    = 17'(a_gi);
    endtask

    task automatic run_frame();
        exp_t e;
        e = model_frame();
        if (e.pass_b) begin
            if (m_fp < 65535) m_fp++;
            if (e.lat > m_wl) m_wl = e.lat;
        end
        e.fp = m_fp;
        e.wl = m_wl;
        exp_q.push_back(e);
        for (int i = 0; i < n_in; i++) cyc(1, 0, 0, 0, 0, 0);
        if (n_in != FFT_SIZE) begin
            cyc(0, 0, 0, 0, 0, 0);
        end else begin
            for (int j = 0; j < g0; j++) cyc(0, 0, 0, 0, 0, 0);
            for (int k = 0; k < FFT_SIZE; k++) begin
                if (k > 0)
                    for (int j = 0; j < gap[k-1]; j++) cyc(0, 0, 0, 0, 0, 0);
                cyc(0, 1, dr[k], di[k], gr[k], gi[k]);
                if (k == iv_inject) cyc(1, 0, 0, 0, 0, 0);
            end
        end
        for (int j = 0; j < idle_after; j++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_const(input int a_gr, input int a_gi, input int a_dr, input int a_di,
                             input int a_g0, input int a_gap);
        n_in = FFT_SIZE;
        g0 = a_g0;
        iv_inject = -1;
        idle_after = 3;
        for (int k = 0; k < FFT_SIZE; k++) begin
            gr[k] = a_gr; gi[k] = a_gi; dr[k] = a_dr; di[k] = a_di; gap[k] = a_gap;
        end
    endtask

    task automatic set_random();
        int mode, amp;
        mode = $urandom_range(0, 19);
        n_in = FFT_SIZE;
        if (mode == 0) n_in = $urandom_range(1, FFT_SIZE-1);
        else if (mode == 1) n_in = FFT_SIZE + 1;
        g0 = $urandom_range(1, 45);
        iv_inject = -1;
        idle_after = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
            0: amp = 0;
            1: amp = 3;
            2: amp = 300;
            default: amp = 3000;
        endcase
        for (int k = 0; k < FFT_SIZE; k++) begin
            gap[k] = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3);
            gr[k] = int'($urandom_range(0, 60000)) - 30000;
            gi[k] = int'($urandom_range(0, 60000)) - 30000;
            dr[k] = clamp16(gr[k] + int'($urandom_range(0, 2*amp)) - amp);
            di[k] = clamp16(gi[k] + int'($urandom_range(0, 2*amp)) - amp);
        end
        if (mode == 2) begin
            // in_valid during CHECK; no stalls so the frame cannot time out first
            iv_inject = $urandom_range(0, FFT_SIZE-2);
            g0 = $urandom_range(1, 40);
            for (int k = 0; k < FFT_SIZE; k++) gap[k] = 0;
        end
    endtask

    // Scoreboard: every done pulse is matched against the oldest expected frame.
    exp_t mon_e;
    exp_t stat_e;
    bit   stats_pending = 0;
    always @(negedge clk) begin
        if (stats_pending) begin
            stats_pending = 0;
            chk("done_one_cycle", bus.done, 0);
            chk("frames_passed", bus.frames_passed, stat_e.fp);
            chk("worst_latency", bus.worst_latency, stat_e.wl);
        end
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pass", bus.pass, mon_e.pass_b);
                chk("timeout", bus.timeout, mon_e.timeout_b);
                chk("proto_err", bus.proto_err, mon_e.proto_b);
                chk("latency", bus.latency, mon_e.lat);
                chk("signal_energy", longint'(bus.signal_energy), mon_e.s);
                chk("noise_energy", longint'(bus.noise_energy), mon_e.n);
`ifdef FFT_CHK_STATS_EN
                stat_e = mon_e;
`else
                stat_e = mon_e;
                stat_e.fp = 0;
                stat_e.wl = 0;
`endif
                stats_pending = 1;
            end
        end
    end

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_done"}, bus.done, 0);
        chk({pfx, "_pass"}, bus.pass, 0);
        chk({pfx, "_timeout"}, bus.timeout, 0);
        chk({pfx, "_proto"}, bus.proto_err, 0);
        chk({pfx, "_latency"}, bus.latency, 0);
        chk({pfx, "_S"}, longint'(bus.signal_energy), 0);
        chk({pfx, "_N"}, longint'(bus.noise_energy), 0);
        chk({pfx, "_fp"}, bus.frames_passed, 0);
        chk({pfx, "_wl"}, bus.worst_latency, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.out_valid = 0;
        bus.dout_r = 0; bus.dout_i = 0; bus.gold_r = 0; bus.gold_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 0;

        // Exact match, latency 10
        set_const(100, 0, 100, 0, 10, 0);
        run_frame();
        // SNR boundary: equality passes, one LSB worse fails
        set_const(1000, 0, 1010, 0, 15, 0);
        run_frame();
        set_const(1000, 0, 1011, 0, 12, 0);
        run_frame();
        // No output at all -> timeout in WAIT
        set_const(100, 0, 100, 0, 100, 0);
        run_frame();
        // Timeout during CHECK via output stalls
        set_const(100, 50, 100, 50, 40, 0);
        for (int k = 0; k < 30; k++) gap[k] = 1;
        run_frame();
        // Early drop of in_valid, then a normal frame
        set_const(100, 0, 100, 0, 10, 0);
        n_in = 20;
        run_frame();
        set_const(-300, 200, -300, 200, 10, 0);
        run_frame();
        // in_valid held past FFT_SIZE
        set_const(100, 0, 100, 0, 10, 0);
        n_in = FFT_SIZE + 1;
        run_frame();
        // in_valid during CHECK
        set_const(500, -500, 501, -500, 8, 0);
        iv_inject = 5;
        run_frame();
        // Full-scale golden vs opposite-rail output
        set_const(-65536, 65535, 32767, -32768, 20, 0);
        run_frame();
        // Back-to-back: next frame starts in the DONE cycle
        set_const(700, 700, 700, 701, 9, 0);
        idle_after = 0;
        run_frame();
        set_const(700, 700, 700, 700, 11, 0);
        run_frame();
        // Frame ending exactly at the latency limit passes
        set_const(20, 20, 20, 20, 37, 0);
        gap[0] = 31;
        run_frame();

        for (int f = 0; f < 40; f++) begin
            set_random();
            run_frame();
        end
        repeat (4) cyc(0, 0, 0, 0, 0, 0);

        // Reset mid-CHECK aborts the frame without a done pulse
        for (int i = 0; i < FFT_SIZE; i++) cyc(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 100, 0, 100, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_S", longint'(bus.signal_energy), 30000);
        chk("pre_reset_latency", bus.latency, 5);
        bus.out_valid = 0;
        reset = 1;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        reset = 0;
        m_fp = 0;
        m_wl = 0;

        // Three passing frames after reset: stats 3 / 15
        set_const(100, 0, 100, 0, 10, 0);
        run_frame();
        set_const(100, 0, 100, 0, 15, 0);
        run_frame();
        set_const(100, 0, 100, 0, 12, 0);
        run_frame();

        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        chk("pass_held", bus.pass, 1);
        chk("frames_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
